// File: rtl/pulse_width_monitor.sv
// Synchronizes two asynchronous waveforms, strobes their edges and measures each
// high pulse in clk cycles; completed pulses are queued as records behind a valid/ready port.
module pulse_width_monitor #(
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_a,
  input  logic             sig_b,
  output logic             rise_a,
  output logic             fall_a,
  output logic             rise_b,
  output logic             fall_b,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_chan,
  output logic [CNT_W-1:0] rec_width,
  output logic             rec_sat,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = CNT_W + 2;

  logic [1:0]             sig;
  logic [SYNC_STAGES-1:0] sync [2];
  logic [1:0]             s, p, rise_r, fall_r;
  logic [CNT_W-1:0]       cnt [2];
  logic [1:0]             sat;
  logic [1:0]             pend_v, pend_sat;
  logic [CNT_W-1:0]       pend_w [2];
  logic [1:0]             wr, drop;

  logic [RW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [AW:0]            count;
  logic                   full, pop, push, can_wr;
  logic [RW-1:0]          wdata, head;

  assign sig = {sig_b, sig_a};
  assign s   = {sync[1][SYNC_STAGES-1], sync[0][SYNC_STAGES-1]};

  // Strobes are registered, so counting keys off p, which is aligned with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < 2; c++) begin
        sync[c]     <= '0;
        cnt[c]      <= '0;
        pend_w[c]   <= '0;
      end
      p        <= '0;
      rise_r   <= '0;
      fall_r   <= '0;
      sat      <= '0;
      pend_v   <= '0;
      pend_sat <= '0;
    end else begin
      p      <= s;
      rise_r <= s & ~p;
      fall_r <= ~s & p;
      for (int unsigned c = 0; c < 2; c++) begin
        sync[c] <= {sync[c][SYNC_STAGES-2:0], sig[c]};
        if (rise_r[c]) begin
          cnt[c] <= CNT_W'(1);
          sat[c] <= 1'b0;
        end else if (p[c]) begin
          if (cnt[c] == '1) sat[c] <= 1'b1;
          else              cnt[c] <= cnt[c] + CNT_W'(1);
        end
        // A slot being written this edge is free to take the new record.
        if (fall_r[c] && !drop[c]) begin
          pend_v[c]   <= 1'b1;
          pend_w[c]   <= cnt[c];
          pend_sat[c] <= sat[c];
        end else if (wr[c]) begin
          pend_v[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pop    = rec_valid & rec_ready;
    full   = (count == (AW+1)'(FIFO_DEPTH));
    can_wr = ~full | pop;
    wr[0]  = pend_v[0] & can_wr;
    wr[1]  = pend_v[1] & ~pend_v[0] & can_wr;
    push   = |wr;
    drop   = fall_r & pend_v & ~wr;
    wdata  = wr[0] ? {1'b0, pend_w[0], pend_sat[0]} : {1'b1, pend_w[1], pend_sat[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (|drop)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rec_valid = (count != '0);
  assign head      = rec_valid ? mem[rptr] : '0;
  assign rec_chan  = head[RW-1];
  assign rec_width = head[RW-2:1];
  assign rec_sat   = head[0];

  assign rise_a = rise_r[0];
  assign fall_a = fall_r[0];
  assign rise_b = rise_r[1];
  assign fall_b = fall_r[1];

endmodule

// File: doc/pulse_width_monitor.md
Name: pulse_width_monitor

Overview:
- Synthesizable downstream consumer for the simulation stimulus stage, which drives two free-running waveforms (a and b) plus a 100 MHz free-running clock.
- Synchronizes both waveforms, flags every edge, and measures each high pulse in clock cycles.
- Queues one record per completed pulse in a small FIFO, drained through a valid/ready port.
- Testbenches use it to self-check stimulus timing instead of reading waveforms by eye.

Parameters:
- CNT_W, 16, width counter bits; record width saturates at 2^CNT_W-1.
- FIFO_DEPTH, 4, record FIFO entries; power of two, >=2.
- SYNC_STAGES, 2, flip-flop synchronizer depth per input; >=2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sig_a  in  1  monitored waveform A, asynchronous to clk.
- sig_b  in  1  monitored waveform B, asynchronous to clk.
- rise_a, fall_a, rise_b, fall_b  out  1 each  one-cycle edge strobes.
- rec_valid  out  1  FIFO head record available.
- rec_ready  in  1  consumer accepts head record.
- rec_chan  out  1  0=A, 1=B.
- rec_width  out  CNT_W  high-pulse length in cycles.
- rec_sat  out  1  width counter saturated.
- overflow  out  1  sticky: a record was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, outputs forced immediately):
  - all synchronizer flops, previous-value flops, counters, pending slots, FIFO pointers, strobes, rec_valid, overflow = 0.
  - rec_chan/rec_width/rec_sat = 0 while FIFO empty.
- Sync/edge: per channel, s = last synchronizer stage and p = s delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
  - Input change to strobe latency = SYNC_STAGES+1 clk edges.
  - An input held high through reset release produces a rise after sync latency.
- Width count: per channel.
  - In the rise cycle, cnt <= 1 and sat <= 0.
  - Each later cycle with s=1: cnt increments; at 2^CNT_W-1 it holds and sat <= 1.
  - In the fall cycle, record {chan, cnt, sat} loads into that channel's pending slot at that edge; cnt is unchanged until the next rise.
  - Width equals the number of cycles s was high.
- Write arbiter: one FIFO write per cycle.
  - Pending A has priority over pending B.
  - A write occurs if the slot is occupied and the FIFO is not full, or is full but popping this same cycle. The slot is freed on write.
  - Simultaneous falls on A and B: A is written the next cycle, B the cycle after.
- Drop rule: a fall on a channel whose pending slot is still occupied overwrites nothing.
  - The new record is discarded and overflow <= 1.
  - overflow stays set until clr_ovf or rst. If clr_ovf and a drop occur in the same cycle, overflow = 1.
- FIFO:
  - Registered read port, no bypass. A record written at edge E is visible with rec_valid=1 after E.
  - Pop when rec_valid & rec_ready.
  - Head outputs hold stable while rec_valid=1 and rec_ready=0.
  - Push and pop in the same cycle when full or empty are both legal; count is unchanged when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: fall strobe cycle F -> pending at end of F -> FIFO write at end of F+1 (uncontended) -> rec_valid high during F+2.
- Mid-operation reset: in-flight counts, pending records, and FIFO contents are discarded. No partial record is emitted after release.

Test Plan:
- Reset/idle: rst high 3 cycles with sig_a=sig_b=0 -> all outputs 0; no strobes 50 cycles after release.
- Single pulse: sig_a high for exactly 7 synchronized cycles (70 ns at 10 ns clk), rec_ready=1.
  - Expect rise_a then fall_a 7 cycles apart.
  - Expect one record {chan=0, width=7, sat=0} with rec_valid 2 cycles after fall_a.
- Simultaneous falls: sig_a and sig_b both high 5 cycles, falling on the same edge.
  - Expect record A(width 5) then B(width 5) on consecutive cycles, A first.
- Backpressure/overflow: rec_ready=0 and FIFO_DEPTH=4; send 6 one-cycle-spaced pulses of width 2 on sig_b.
  - Expect 4 records queued, pending slot holding the 5th, 6th dropped, overflow=1.
  - Then rec_ready=1 -> 5 records drained in order; clr_ovf -> overflow=0.
- Saturation: CNT_W=4, sig_a high 20 cycles -> record width=15, sat=1; next pulse of 3 cycles -> width=3, sat=0.
- Reset mid-pulse: sig_a high, assert rst after 4 high cycles, release with sig_a still high, fall 6 cycles later.
  - Expect fresh rise_a after sync latency and a single record width=6; no record from the pre-reset pulse.
